data_memory_controller: RTL
===========================

// Module: data_memory_controller
// PURPOSE
// - Memory-side responder for the LSU data-memory handshake: accepts read/write requests from NUM_CHANNELS LSUs and answers each with a one-cycle ready pulse.
// - Serialises channel requests onto one downstream data-memory port. Requests are granted round-robin, with one transaction outstanding at a time.
// - Sits between the per-thread LSUs of a core and the data memory, or the next-level memory controller.
// PARAMETERS
// - NUM_CHANNELS  4  number of LSU channels served; >= 1
// PORTS
// - clk                     in   1               single clock; all state changes on posedge
// - reset_n                 in   1               asynchronous, active-low reset
// - consumer_read_valid     in   NUM_CHANNELS    per-channel LSU read request
// - consumer_read_address   in   [N] addr_t      per-channel read address (data_memory_address_t)
// - consumer_read_ready     out  NUM_CHANNELS    per-channel read-complete pulse
// - consumer_read_data      out  [N] data_t      per-channel read data; held until the next read on that channel
// - consumer_write_valid    in   NUM_CHANNELS    per-channel LSU write request
// - consumer_write_address  in   [N] addr_t      per-channel write address
// - consumer_write_data     in   [N] data_t      per-channel write data
// - consumer_write_ready    out  NUM_CHANNELS    per-channel write-complete pulse
// - mem_read_valid          out  1               downstream read request
// - mem_read_address        out  addr_t          downstream read address
// - mem_read_ready          in   1               downstream read done; mem_read_data is valid in the same cycle
// - mem_read_data           in   data_t          downstream read data
// - mem_write_valid         out  1               downstream write request
// - mem_write_address       out  addr_t          downstream write address
// - mem_write_data          out  data_t          downstream write data
// - mem_write_ready         in   1               downstream write done
// BEHAVIOUR
// - Reset (reset_n low, asynchronous)
//   - All outputs go to 0, state = CTRL_IDLE, rr_ptr = 0.
//   - Any in-flight transaction is abandoned; no ready pulse is issued for it.
// - FSM states: CTRL_IDLE, CTRL_READ_WAIT, CTRL_WRITE_WAIT, CTRL_RESPOND. All outputs are registered.
// - CTRL_IDLE
//   - pending[i] = read_valid[i] | write_valid[i].
//   - Grant the first pending channel at or after rr_ptr, wrapping modulo NUM_CHANNELS.
//   - On grant: latch channel id, address and data; assert mem_read_valid or mem_write_valid (downstream valid high the cycle after grant); go to READ_WAIT or WRITE_WAIT.
//   - If read and write are both valid on one channel, read wins. The write stays pending and is granted in a later IDLE pass.
// - READ_WAIT: on mem_read_ready
//   - capture mem_read_data into consumer_read_data[ch];
//   - set consumer_read_ready[ch] = 1; mem_read_valid = 0; go to RESPOND.
// - WRITE_WAIT: on mem_write_ready
//   - set consumer_write_ready[ch] = 1; mem_write_valid = 0; go to RESPOND.
// - CTRL_RESPOND (exactly one cycle)
//   - The ready pulse is visible to the LSU during this cycle.
//   - At its end: clear all consumer ready bits; rr_ptr = (ch+1) mod NUM_CHANNELS; go to IDLE.
//   - The LSU drops its valid at this same edge, so the next IDLE never re-grants a completed request. No extra settle cycle is needed.
// - Ready pulse rules
//   - Ready pulses are one-hot and last exactly one cycle.
//   - At most one pulse in any cycle across all channels and both directions.
// - Latency
//   - Downstream ready in cycle k gives consumer ready in cycle k+1.
//   - Minimum request-to-ready (LSU valid seen to ready) is 3 cycles with zero-wait memory.
// - Ignored inputs
//   - mem_*_ready arriving outside the matching WAIT state is ignored.
//   - Address and data changes on the granted channel after grant are ignored (latched copy used).
// - Withdrawn request: if a channel drops valid during WAIT, the transaction still completes downstream and the pulse is still issued.
// - Fairness: with N channels continuously requesting, each channel is served once per N transactions.
// - Widths: rr_ptr and ch are $clog2(NUM_CHANNELS) bits, minimum 1. Wrap uses an explicit compare to NUM_CHANNELS-1 (non-power-of-2 safe).
// STRUCTURE
// - common.sv additions:
//   - typedef enum controller_state_t {CTRL_IDLE, CTRL_READ_WAIT, CTRL_WRITE_WAIT, CTRL_RESPOND};
//   - reuse data_t and data_memory_address_t unchanged.
// - Sub-module rr_arbiter: combinational; inputs pending and rr_ptr; outputs grant_valid and grant_idx.
// - Everything else (FSM, latches, output regs) lives in data_memory_controller.
// TESTING
// 1. Reset: hold reset_n=0 mid-READ_WAIT on ch1.
//    -> all outputs 0 immediately (async). After release with no requests: mem_read_valid stays 0.
// 2. Single read, ch2 addr=0x10, zero-wait memory returning 0xDEAD.
//    -> mem_read_address=0x10 one cycle after grant; read_ready[2] high for exactly 1 cycle; read_data[2]=0xDEAD, held afterwards.
// 3. Single write, ch0 addr=0x20 data=0x55, memory waits 3 cycles.
//    -> mem_write_data=0x55 held through the wait; write_ready[0] pulses once, the cycle after mem_write_ready.
// 4. All 4 channels request reads simultaneously from reset.
//    -> grant order 0,1,2,3; then ch0 re-requests with ch3 also requesting -> order continues ch0 (rr_ptr wrapped).
// 5. ch1 read and ch2 write pending with rr_ptr=1.
//    -> ch1 read first, then ch2 write; the two ready pulses never overlap; no duplicate grant to ch1.
// 6. Spurious mem_read_ready in IDLE and mem_write_ready during READ_WAIT.
//    -> no consumer ready pulse; FSM state unchanged.

Source files
------------

// File: rtl/data_memory_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_controller_pkg
// Description : Shared types for the LSU data-memory controller: data and
//               address types, controller FSM encoding, index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_controller_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] data_memory_address_t;

  typedef enum logic [1:0] {
    CTRL_IDLE       = 2'd0,
    CTRL_READ_WAIT  = 2'd1,
    CTRL_WRITE_WAIT = 2'd2,
    CTRL_RESPOND    = 2'd3
  } controller_state_t;

  // Channel index width; never below 1 so a single-channel build still has
  // a legal vector for the pointer and channel id.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_controller_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_controller_rr_arbiter
// Description : Combinational round-robin picker. Returns the first pending
//               channel at or after rr_ptr, wrapping modulo NUM_CHANNELS.
// Ports       : pending     in  per-channel request flags
//               rr_ptr      in  channel with highest priority this pass
//               grant_valid out any channel pending
//               grant_idx   out selected channel
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_controller_rr_arbiter
  import data_memory_controller_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int IDX_W        = idx_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] pending,
  input  logic [IDX_W-1:0]        rr_ptr,
  output logic                    grant_valid,
  output logic [IDX_W-1:0]        grant_idx
);

  logic [IDX_W:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest pending channel
  // is the last one written and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_idx       = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      w_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (w_idx >= (IDX_W+1)'(NUM_CHANNELS)) begin
        w_idx = w_idx - (IDX_W+1)'(NUM_CHANNELS);
      end
      if (pending[w_idx[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_controller.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_controller
// Description : Serialises LSU read/write requests from NUM_CHANNELS channels
//               onto a single downstream data-memory port, one transaction
//               at a time, granted round-robin. Each completion is answered
//               with a one-cycle ready pulse on the owning channel.
// Ports       : clk, reset_n (async, active-low)
//               consumer_read_*  / consumer_write_*  LSU-side handshake
//               mem_read_*       / mem_write_*       downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_controller
  import data_memory_controller_pkg::*;
#(
  parameter int NUM_CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CHANNELS-1:0]   consumer_read_valid,
  input  data_memory_address_t      consumer_read_address  [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]   consumer_read_ready,
  output data_t                     consumer_read_data     [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]   consumer_write_valid,
  input  data_memory_address_t      consumer_write_address [NUM_CHANNELS],
  input  data_t                     consumer_write_data    [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]   consumer_write_ready,
  output logic                      mem_read_valid,
  output data_memory_address_t      mem_read_address,
  input  logic                      mem_read_ready,
  input  data_t                     mem_read_data,
  output logic                      mem_write_valid,
  output data_memory_address_t      mem_write_address,
  output data_t                     mem_write_data,
  input  logic                      mem_write_ready
);

  localparam int IDX_W = idx_width(NUM_CHANNELS);

  controller_state_t r_state;
  controller_state_t w_next_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_ch;

  logic                    w_grant_valid;
  logic [IDX_W-1:0]        w_grant_idx;
  logic                    w_grant_is_read;
  logic                    w_issue_read;
  logic                    w_issue_write;
  logic                    w_finish_read;
  logic                    w_finish_write;
  logic                    w_respond;

  data_memory_controller_rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .IDX_W        (IDX_W)
  ) u_rr_arbiter (
    .pending     (consumer_read_valid | consumer_write_valid),
    .rr_ptr      (r_rr_ptr),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // Read wins when a channel has both directions pending; the write stays
  // asserted by the LSU and is picked up on a later idle pass.
  assign w_grant_is_read = consumer_read_valid[w_grant_idx];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CTRL_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CTRL_IDLE: begin
        if (w_issue_read)       w_next_state = CTRL_READ_WAIT;
        else if (w_issue_write) w_next_state = CTRL_WRITE_WAIT;
      end
      CTRL_READ_WAIT:  if (w_finish_read)  w_next_state = CTRL_RESPOND;
      CTRL_WRITE_WAIT: if (w_finish_write) w_next_state = CTRL_RESPOND;
      CTRL_RESPOND:    w_next_state = CTRL_IDLE;
      default:         w_next_state = CTRL_IDLE;
    endcase
  end

  // Output decode: downstream readies only count in their own wait state.
  always_comb begin
    w_issue_read   = 1'b0;
    w_issue_write  = 1'b0;
    w_finish_read  = 1'b0;
    w_finish_write = 1'b0;
    w_respond      = 1'b0;
    case (r_state)
      CTRL_IDLE: begin
        w_issue_read  = w_grant_valid &  w_grant_is_read;
        w_issue_write = w_grant_valid & ~w_grant_is_read;
      end
      CTRL_READ_WAIT:  w_finish_read  = mem_read_ready;
      CTRL_WRITE_WAIT: w_finish_write = mem_write_ready;
      CTRL_RESPOND:    w_respond      = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs and latched transaction context. Address/data are
  // copied at grant so later LSU-side changes cannot disturb the transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch                 <= '0;
      r_rr_ptr             <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        consumer_read_data[i] <= '0;
      end
    end else begin
      if (w_issue_read) begin
        r_ch             <= w_grant_idx;
        mem_read_valid   <= 1'b1;
        mem_read_address <= consumer_read_address[w_grant_idx];
      end
      if (w_issue_write) begin
        r_ch              <= w_grant_idx;
        mem_write_valid   <= 1'b1;
        mem_write_address <= consumer_write_address[w_grant_idx];
        mem_write_data    <= consumer_write_data[w_grant_idx];
      end
      if (w_finish_read) begin
        consumer_read_data[r_ch]  <= mem_read_data;
        consumer_read_ready[r_ch] <= 1'b1;
        mem_read_valid            <= 1'b0;
      end
      if (w_finish_write) begin
        consumer_write_ready[r_ch] <= 1'b1;
        mem_write_valid            <= 1'b0;
      end
      if (w_respond) begin
        consumer_read_ready  <= '0;
        consumer_write_ready <= '0;
        // Explicit compare keeps the wrap correct for non-power-of-2 counts.
        r_rr_ptr <= (r_ch == IDX_W'(NUM_CHANNELS - 1)) ? '0 : r_ch + IDX_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
